// File: rtl/clk_div_monitor.sv
// clk_div_monitor
// Brings the slow divided clock c0 into the fast inclk0 domain and turns its
// edges into single-cycle rise/fall strobes. Each half-period is measured in
// fast cycles and checked against EXPECTED_HALF. The block reports lock, counts
// loss-of-lock events, and flags a stopped c0.
module clk_div_monitor #(
    parameter int EXPECTED_HALF = 8,
    parameter int TOL           = 1,
    parameter int LOCK_COUNT    = 4,
    parameter int CNT_W         = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             inclk0,
    input  logic             reset,
    input  logic             c0_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout,
    output logic [7:0]       lost_count
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] EXP_C       = CNT_W'(EXPECTED_HALF);
    localparam logic [CNT_W-1:0] TOL_C       = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(4 * EXPECTED_HALF);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [GOOD_W-1:0] GOOD_LAST  = GOOD_W'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    // Synchroniser chain, history flop and strobe registers
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s_d_reg;
    logic                   rise_reg;
    logic                   fall_reg;
    logic                   s_sync;
    logic                   c0_edge;

    // Measurement and FSM state
    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [GOOD_W-1:0] good_reg, good_next;
    logic [CNT_W-1:0]  hp_reg, hp_next;
    logic              pv_reg, pv_next;
    logic              locked_reg, locked_next;
    logic              timeout_reg, timeout_next;
    logic [7:0]        lost_reg, lost_next;

    logic [CNT_W-1:0]  diff;
    logic              in_tol;
    logic [7:0]        lost_inc;

    assign s_sync  = sync_reg[SYNC_STAGES-1];
    assign c0_edge = s_sync ^ s_d_reg;

    // Absolute deviation computed by ordering the operands, so it never wraps
    assign diff   = (cnt_reg >= EXP_C) ? (cnt_reg - EXP_C) : (EXP_C - cnt_reg);
    assign in_tol = (diff <= TOL_C);

    assign lost_inc = (lost_reg != 8'hFF) ? (lost_reg + 8'd1) : lost_reg;

    // Shift c0 through the synchroniser and register the edge strobes
    always_ff @(posedge inclk0) begin
        if (reset) begin
            sync_reg <= '0;
            s_d_reg  <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], c0_in};
            s_d_reg  <= s_sync;
            rise_reg <= s_sync & ~s_d_reg;
            fall_reg <= ~s_sync & s_d_reg;
        end
    end

    // Saturating cycle counter, restarted at 1 on every synchronised edge
    always_comb begin
        cnt_next = cnt_reg;
        if (c0_edge) begin
            cnt_next = CNT_W'(1);
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Next-state and measurement outputs; an edge always takes priority
    // over the stopped-clock threshold
    always_comb begin
        state_next   = state_reg;
        good_next    = good_reg;
        hp_next      = hp_reg;
        pv_next      = 1'b0;
        locked_next  = locked_reg;
        timeout_next = timeout_reg;
        lost_next    = lost_reg;
        case (state_reg)
            IDLE: begin
                // First edge only arms the measurement; its count is partial
                if (c0_edge) begin
                    state_next   = ACQUIRE;
                    timeout_next = 1'b0;
                    good_next    = '0;
                end
            end
            ACQUIRE: begin
                if (c0_edge) begin
                    hp_next = cnt_reg;
                    pv_next = 1'b1;
                    if (in_tol) begin
                        good_next = good_reg + GOOD_W'(1);
                        if (good_reg == GOOD_LAST) begin
                            state_next  = LOCKED;
                            locked_next = 1'b1;
                        end
                    end else begin
                        good_next = '0;
                    end
                end else if (cnt_reg >= TIMEOUT_CNT) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                    locked_next  = 1'b0;
                    good_next    = '0;
                end
            end
            LOCKED: begin
                if (c0_edge) begin
                    hp_next = cnt_reg;
                    pv_next = 1'b1;
                    if (!in_tol) begin
                        state_next  = ACQUIRE;
                        locked_next = 1'b0;
                        good_next   = '0;
                        lost_next   = lost_inc;
                    end
                end else if (cnt_reg >= TIMEOUT_CNT) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                    locked_next  = 1'b0;
                    good_next    = '0;
                    lost_next    = lost_inc;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and measurement registers
    always_ff @(posedge inclk0) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            good_reg    <= '0;
            hp_reg      <= '0;
            pv_reg      <= 1'b0;
            locked_reg  <= 1'b0;
            timeout_reg <= 1'b0;
            lost_reg    <= 8'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            good_reg    <= good_next;
            hp_reg      <= hp_next;
            pv_reg      <= pv_next;
            locked_reg  <= locked_next;
            timeout_reg <= timeout_next;
            lost_reg    <= lost_next;
        end
    end

    assign rise_pulse   = rise_reg;
    assign fall_pulse   = fall_reg;
    assign half_period  = hp_reg;
    assign period_valid = pv_reg;
    assign locked       = locked_reg;
    assign timeout      = timeout_reg;
    assign lost_count   = lost_reg;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor
// Directed bench for clk_div_monitor: c0_in is driven on falling edges of the
// fast clock, outputs are sampled on falling edges, expected values are
// hand-derived for EXPECTED_HALF=8, TOL=1, LOCK_COUNT=4, SYNC_STAGES=2.
module tb_clk_div_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        c0_in = 1'b0;
    logic        rise_pulse;
    logic        fall_pulse;
    logic [15:0] half_period;
    logic        period_valid;
    logic        locked;
    logic        timeout;
    logic [7:0]  lost_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Running observations gathered once per cycle
    int          rise_cnt;
    int          fall_cnt;
    int          pv_cnt;
    int          first_pv_strobe;
    int          lock_pv;
    logic        lock_seen;
    logic [15:0] last_hp;
    logic        pv_locked_last;
    int          pv_snap;

    clk_div_monitor #(
        .EXPECTED_HALF(8),
        .TOL(1),
        .LOCK_COUNT(4),
        .CNT_W(16),
        .SYNC_STAGES(2)
    ) dut (
        .inclk0(clk),
        .reset(reset),
        .c0_in(c0_in),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .half_period(half_period),
        .period_valid(period_valid),
        .locked(locked),
        .timeout(timeout),
        .lost_count(lost_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rise_cnt        = 0;
        fall_cnt        = 0;
        pv_cnt          = 0;
        first_pv_strobe = 0;
        lock_pv         = 0;
        lock_seen       = 1'b0;
        last_hp         = '0;
        pv_locked_last  = 1'b0;
    endtask

    // Advance one cycle, sample at the falling edge, check per-cycle invariants
    task automatic cyc();
        @(negedge clk);
        chk("strobe_exclusive", 32'(rise_pulse & fall_pulse), 0);
        chk("pv_needs_strobe", 32'(period_valid & ~(rise_pulse | fall_pulse)), 0);
        if (rise_pulse === 1'b1) rise_cnt++;
        if (fall_pulse === 1'b1) fall_cnt++;
        if (period_valid === 1'b1) begin
            pv_cnt++;
            last_hp        = half_period;
            pv_locked_last = locked;
            if (first_pv_strobe == 0) first_pv_strobe = rise_cnt + fall_cnt;
        end
        if (locked === 1'b1 && !lock_seen) begin
            lock_seen = 1'b1;
            lock_pv   = pv_cnt;
        end
    endtask

    // Toggle c0 and hold it for n fast cycles
    task automatic half(input int n);
        c0_in = ~c0_in;
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        c0_in = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rise"}, 32'(rise_pulse), 0);
        chk({tag, "_fall"}, 32'(fall_pulse), 0);
        chk({tag, "_hp"}, 32'(half_period), 0);
        chk({tag, "_pv"}, 32'(period_valid), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
        chk({tag, "_lost"}, 32'(lost_count), 0);
    endtask

    initial begin
        clear_mon();

        // Reset state, during and on the first cycle after
        reset = 1'b1;
        repeat (2) cyc();
        chk_zero("rst");
        reset = 1'b0;
        clear_mon();
        cyc();
        chk_zero("post_rst");

        // First edge: strobe latency of three cycles, no period_valid
        c0_in = 1'b1;
        cyc();
        cyc();
        chk("lat_early", 32'(rise_pulse), 0);
        cyc();
        chk("lat_exact", 32'(rise_pulse), 1);
        chk("first_edge_no_pv", 32'(period_valid), 0);
        repeat (5) cyc();

        // Four more edges at 8: lock on the 4th measurement
        repeat (4) half(8);
        $display("step lock8: rise=%0d fall=%0d pv=%0d hp=%0d locked=%0d", rise_cnt, fall_cnt, pv_cnt, last_hp, locked);
        chk("l8_rise", 32'(rise_cnt), 3);
        chk("l8_fall", 32'(fall_cnt), 2);
        chk("l8_pv", 32'(pv_cnt), 4);
        chk("l8_first_pv_strobe", 32'(first_pv_strobe), 2);
        chk("l8_hp", 32'(last_hp), 8);
        chk("l8_locked", 32'(locked), 1);
        chk("l8_lock_pv", 32'(lock_pv), 4);
        chk("l8_lost", 32'(lost_count), 0);

        // One long half-period of 12 breaks lock on the very measurement
        half(12);
        half(8);
        $display("step glitch12: hp=%0d locked=%0d lost=%0d", last_hp, locked, lost_count);
        chk("g12_hp", 32'(last_hp), 12);
        chk("g12_locked_on_pv", 32'(pv_locked_last), 0);
        chk("g12_locked", 32'(locked), 0);
        chk("g12_lost", 32'(lost_count), 1);
        repeat (3) half(8);
        chk("relock_early", 32'(locked), 0);
        half(8);
        chk("relock", 32'(locked), 1);
        chk("relock_hp", 32'(last_hp), 8);

        // Stop c0: last toggle was 8 cycles ago, threshold lands 35 after it
        repeat (26) cyc();
        chk("to_early", 32'(timeout), 0);
        chk("to_early_locked", 32'(locked), 1);
        cyc();
        $display("step timeout: timeout=%0d locked=%0d lost=%0d", timeout, locked, lost_count);
        chk("to_set", 32'(timeout), 1);
        chk("to_locked", 32'(locked), 0);
        chk("to_lost", 32'(lost_count), 2);
        repeat (10) cyc();
        chk("to_hold", 32'(timeout), 1);
        chk("to_no_double", 32'(lost_count), 2);

        // Resume: timeout clears on first edge, which carries no period_valid
        pv_snap = pv_cnt;
        half(8);
        chk("resume_to", 32'(timeout), 0);
        chk("resume_no_pv", 32'(pv_cnt), 32'(pv_snap));
        repeat (3) half(8);
        chk("resume_lock_early", 32'(locked), 0);
        half(8);
        chk("resume_lock", 32'(locked), 1);

        // Third loss, relock, then one-cycle reset mid-operation
        half(12);
        repeat (5) half(8);
        chk("loss3_lost", 32'(lost_count), 3);
        chk("loss3_locked", 32'(locked), 1);
        reset = 1'b1;
        c0_in = 1'b0;
        cyc();
        $display("step midreset: locked=%0d lost=%0d hp=%0d", locked, lost_count, half_period);
        chk_zero("midrst");
        reset = 1'b0;
        clear_mon();
        repeat (4) half(8);
        chk("rst_relock_early", 32'(locked), 0);
        half(8);
        chk("rst_relock", 32'(locked), 1);
        chk("rst_relock_first_pv", 32'(first_pv_strobe), 2);
        chk("rst_relock_lost", 32'(lost_count), 0);

        // Period 9 is within tolerance and locks
        do_reset();
        repeat (5) half(9);
        $display("step period9: hp=%0d locked=%0d", last_hp, locked);
        chk("p9_locked", 32'(locked), 1);
        chk("p9_hp", 32'(last_hp), 9);
        chk("p9_lock_pv", 32'(lock_pv), 4);

        // Period 10 is out of tolerance and never locks
        do_reset();
        repeat (6) half(10);
        $display("step period10: hp=%0d locked=%0d pv=%0d", last_hp, locked, pv_cnt);
        chk("p10_locked", 32'(locked), 0);
        chk("p10_lock_seen", 32'(lock_seen), 0);
        chk("p10_hp", 32'(last_hp), 10);
        chk("p10_pv", 32'(pv_cnt), 5);
        chk("p10_lost", 32'(lost_count), 0);

        // 256 lock losses: lost_count saturates at 255
        do_reset();
        repeat (5) half(8);
        chk("sat_start_locked", 32'(locked), 1);
        for (int i = 0; i < 256; i++) begin
            half(12);
            repeat (5) half(8);
            if (i == 253) chk("sat_254", 32'(lost_count), 254);
            if (i == 254) chk("sat_255", 32'(lost_count), 255);
        end
        $display("step saturate: lost=%0d locked=%0d", lost_count, locked);
        chk("sat_hold", 32'(lost_count), 255);
        chk("sat_locked", 32'(locked), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
